// File: rtl/param_clb.sv
// param_clb: parameterised configurable logic block.
// NUM_LUT K-input LUTs with optional output flip-flops and NUM_OUT output
// muxes, configured through a serial shadow register that is copied into
// the active configuration on a commit.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   din          data inputs (registered every cycle)
//   ce           clock enable for the LUT flip-flops
//   cfg_en       shift one config bit (cfg_in) into the shadow register
//   cfg_in       serial config bit
//   cfg_commit   copy shadow to active config when the load is complete
//   dout         CLB outputs (forced to 0 until configured)
//   cfg_full     exactly CFG_BITS bits shifted since last commit/reset
//   cfg_err      sticky: commit attempted with an incomplete load
//   configured   a valid commit has occurred
module param_clb #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned K       = 3,
  parameter int unsigned NUM_LUT = 2,
  parameter int unsigned NUM_OUT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IN-1:0]  din,
  input  logic               ce,
  input  logic               cfg_en,
  input  logic               cfg_in,
  input  logic               cfg_commit,
  output logic [NUM_OUT-1:0] dout,
  output logic               cfg_full,
  output logic               cfg_err,
  output logic               configured
);

  localparam int unsigned SW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned OSW       = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;
  localparam int unsigned MASK_W    = 1 << K;
  localparam int unsigned LUT_W     = K * SW + MASK_W + 2;
  localparam int unsigned OSEL_BASE = NUM_LUT * LUT_W;
  localparam int unsigned CFG_BITS  = OSEL_BASE + NUM_OUT * OSW;
  localparam int unsigned CNT_W     = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    ST_UNCONFIG = 2'd0,
    ST_LOADING  = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_IN-1:0]   din_q;
  logic [NUM_LUT-1:0]  lut_ff_q, lut_ff_d;
  logic                cfg_err_q, cfg_err_d;
  logic                configured_q, configured_d;
  logic                commit_ok;
  logic [NUM_LUT-1:0]  lut_res;
  logic [NUM_LUT-1:0]  lut_out;
  logic [NUM_OUT-1:0]  dout_c;

  assign cfg_full   = (cnt_q == CNT_W'(CFG_BITS));
  assign cfg_err    = cfg_err_q;
  assign configured = configured_q;
  assign dout       = dout_c;

  // Configuration control: shadow shift, counter, commit and state.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    cfg_err_d    = cfg_err_q;
    configured_d = configured_q;
    commit_ok    = cfg_commit && cfg_full;

    if (cfg_en) begin
      shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
      if (!cfg_full) cnt_d = cnt_q + CNT_W'(1);
    end

    // Commit takes the pre-shift shadow; a simultaneous shift starts the next load.
    if (commit_ok) begin
      active_d     = shadow_q;
      configured_d = 1'b1;
      cfg_err_d    = 1'b0;
      cnt_d        = cfg_en ? CNT_W'(1) : CNT_W'(0);
    end else if (cfg_commit) begin
      cfg_err_d = 1'b1;
    end

    case (state_q)
      ST_UNCONFIG: if (cfg_en) state_d = ST_LOADING;
      ST_LOADING:  if (commit_ok) state_d = cfg_en ? ST_LOADING : ST_ACTIVE;
      ST_ACTIVE:   if (cfg_en) state_d = ST_LOADING;
      default:     state_d = ST_UNCONFIG;
    endcase
  end

  // LUT evaluation, LUT flip-flop next state and output muxes.
  always_comb begin : datapath
    logic [SW-1:0]  sel;
    logic [K-1:0]   addr;
    logic [OSW-1:0] osel;
    logic           val;
    sel      = '0;
    addr     = '0;
    osel     = '0;
    val      = 1'b0;
    lut_res  = '0;
    lut_out  = '0;
    lut_ff_d = lut_ff_q;
    dout_c   = '0;

    for (int unsigned j = 0; j < NUM_LUT; j++) begin
      addr = '0;
      for (int unsigned i = 0; i < K; i++) begin
        sel = active_q[j*LUT_W + i*SW +: SW];
        // Out-of-range select indices read as 0.
        for (int unsigned n = 0; n < NUM_IN; n++) begin
          if (sel == SW'(n)) addr[i] = din_q[n];
        end
      end
      lut_res[j] = active_q[j*LUT_W + K*SW + 32'(addr)];
      lut_out[j] = active_q[j*LUT_W + K*SW + MASK_W] ? lut_ff_q[j] : lut_res[j];

      if (commit_ok)
        lut_ff_d[j] = shadow_q[j*LUT_W + LUT_W - 1];
      else if (ce)
        lut_ff_d[j] = lut_res[j];
    end

    for (int unsigned o = 0; o < NUM_OUT; o++) begin
      osel = active_q[OSEL_BASE + o*OSW +: OSW];
      val  = 1'b0;
      for (int unsigned n = 0; n < NUM_LUT; n++) begin
        if (osel == OSW'(n)) val = lut_out[n];
      end
      dout_c[o] = configured_q & val;
    end
  end

  // State register; reset overrides every other control input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNCONFIG;
      shadow_q     <= '0;
      active_q     <= '0;
      cnt_q        <= '0;
      din_q        <= '0;
      lut_ff_q     <= '0;
      cfg_err_q    <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      din_q        <= din;
      lut_ff_q     <= lut_ff_d;
      cfg_err_q    <= cfg_err_d;
      configured_q <= configured_d;
    end
  end

endmodule

// File: tb/tb_param_clb.sv
// Directed self-checking bench for param_clb at default parameters.
module tb_param_clb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = '0;
  logic       ce = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_in = 1'b0;
  logic       cfg_commit = 1'b0;
  logic [1:0] dout;
  logic       cfg_full;
  logic       cfg_err;
  logic       configured;

  int passed = 0;
  int total  = 0;

  logic [33:0] cfg1, cfg2, cfg3;

  param_clb dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .ce         (ce),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_commit (cfg_commit),
    .dout       (dout),
    .cfg_full   (cfg_full),
    .cfg_err    (cfg_err),
    .configured (configured)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LUT0: sel 0,1,2, mask m0; LUT1: sel 0,0,0, mask m1, comb; osel0=0, osel1=1.
  function automatic logic [33:0] make_cfg(input logic reg_en, input logic ff_init,
                                           input logic [7:0] m0, input logic [7:0] m1);
    logic [33:0] v;
    v        = '0;
    v[5:0]   = 6'b10_01_00;
    v[13:6]  = m0;
    v[14]    = reg_en;
    v[15]    = ff_init;
    v[29:22] = m1;
    v[32]    = 1'b0;
    v[33]    = 1'b1;
    return v;
  endfunction

  task automatic shift_bits(input logic [33:0] v, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cfg_en = 1'b1;
      cfg_in = v[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    cfg1 = make_cfg(1'b0, 1'b0, 8'h96, 8'hFF);
    cfg2 = make_cfg(1'b1, 1'b1, 8'h96, 8'hFF);
    cfg3 = make_cfg(1'b0, 1'b0, 8'h00, 8'hFF);

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_full", 32'(cfg_full), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_cfgd", 32'(configured), 32'd0);

    // Basic combinational load (parity mask)
    shift_bits(cfg1, 0, 33);
    chk("full_33", 32'(cfg_full), 32'd0);
    shift_bits(cfg1, 33, 34);
    chk("full_34", 32'(cfg_full), 32'd1);
    commit();
    chk("c1_cfgd", 32'(configured), 32'd1);
    chk("c1_full", 32'(cfg_full), 32'd0);
    chk("c1_dout_din0", 32'(dout), 32'b10);
    din = 4'b0011; tick();
    chk("c1_din3", 32'(dout), 32'b10);
    din = 4'b0001; tick();
    chk("c1_din1", 32'(dout), 32'b11);

    // Shadow load while active leaves the old config driving
    shift_bits(cfg3, 0, 34);
    chk("shadow_old_din1", 32'(dout), 32'b11);
    din = 4'b0011; tick();
    chk("shadow_old_din3", 32'(dout), 32'b10);
    din = 4'b0001; tick();
    chk("shadow_old_din1b", 32'(dout), 32'b11);
    commit();
    for (int d = 0; d < 16; d++) begin
      din = 4'(d); tick();
      chk($sformatf("zero_mask_din%0d", d), 32'(dout), 32'b10);
    end

    // Registered LUT with ff_init=1
    shift_bits(cfg2, 0, 34);
    commit();
    chk("ff_init", 32'(dout), 32'b11);
    din = 4'b0011; tick();
    chk("ce0_hold_a", 32'(dout), 32'b11);
    din = 4'b0000; tick();
    chk("ce0_hold_b", 32'(dout), 32'b11);
    din = 4'b0001; tick();
    chk("ce0_hold_c", 32'(dout), 32'b11);
    ce = 1'b1; tick();
    chk("ce1_din1", 32'(dout), 32'b11);
    din = 4'b0011; tick();
    chk("ce1_lat1", 32'(dout), 32'b11);
    tick();
    chk("ce1_lat2", 32'(dout), 32'b10);
    ce = 1'b0;

    // Premature commit sets cfg_err; completed load clears it
    reset = 1'b1; tick(); reset = 1'b0;
    shift_bits(cfg1, 0, 20);
    commit();
    chk("early_err", 32'(cfg_err), 32'd1);
    chk("early_cfgd", 32'(configured), 32'd0);
    chk("early_dout", 32'(dout), 32'd0);
    shift_bits(cfg1, 20, 34);
    chk("late_full", 32'(cfg_full), 32'd1);
    commit();
    chk("late_err", 32'(cfg_err), 32'd0);
    chk("late_cfgd", 32'(configured), 32'd1);
    chk("late_dout", 32'(dout), 32'b10);

    // Reset mid-load discards the partial load
    shift_bits(cfg1, 0, 10);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_full", 32'(cfg_full), 32'd0);
    chk("midrst_cfgd", 32'(configured), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    shift_bits(cfg1, 0, 33);
    chk("midrst_33_full", 32'(cfg_full), 32'd0);
    commit();
    chk("midrst_33_err", 32'(cfg_err), 32'd1);
    chk("midrst_33_cfgd", 32'(configured), 32'd0);
    shift_bits(cfg1, 33, 34);
    chk("midrst_34_full", 32'(cfg_full), 32'd1);
    commit();
    chk("midrst_cfgd2", 32'(configured), 32'd1);
    chk("midrst_err2", 32'(cfg_err), 32'd0);

    // Commit and shift in the same cycle
    din = 4'b0001; tick();
    chk("pre_both_dout", 32'(dout), 32'b11);
    shift_bits(cfg3, 0, 34);
    cfg_commit = 1'b1; cfg_en = 1'b1; cfg_in = cfg1[0];
    tick();
    cfg_commit = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    chk("both_full", 32'(cfg_full), 32'd0);
    chk("both_err", 32'(cfg_err), 32'd0);
    chk("both_dout", 32'(dout), 32'b10);
    shift_bits(cfg1, 1, 33);
    chk("both_cnt33", 32'(cfg_full), 32'd0);
    shift_bits(cfg1, 33, 34);
    chk("both_cnt34", 32'(cfg_full), 32'd1);
    commit();
    chk("both_next_dout", 32'(dout), 32'b11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
